// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider and its inverse multiplier:
// FSM state encoding and default operand widths.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int QW_DEF = 8;
  localparam int BW_DEF = 4;

endpackage

// File: rtl/div_inverse_mul.sv
// Shift-add reconstruction of a dividend, p = q*b + r, from divider outputs.
// Optional legality checker on err is built only when DIV_INV_CHECK_EN is defined.
module div_inverse_mul
  import div_pkg::*;
#(
  parameter int QW = QW_DEF,
  parameter int BW = BW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [QW-1:0] q,
  input  logic [BW-1:0] b,
  input  logic [BW-1:0] r,
  input  logic          start,
  output logic [QW+BW-1:0] p,
  output logic          ovf,
  output logic          err,
  output logic          busy,
  output logic          done
);

  localparam int PW = QW + BW;
  localparam int CW = (BW > 1) ? $clog2(BW) : 1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [QW-1:0] r_q;
  logic [BW-1:0] r_b;
  logic [PW-1:0] r_acc;
  logic [PW-1:0] w_addend;
  logic [PW-1:0] w_acc_nxt;
  logic          w_last;
  logic          w_latch;

  always_comb begin
    w_addend  = r_b[r_cnt] ? ({{BW{1'b0}}, r_q} << r_cnt) : '0;
    w_acc_nxt = r_acc + w_addend;
    w_last    = (r_state == CALC) && (r_cnt == CW'(BW - 1));
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = CALC;
          w_latch     = 1'b1;
        end
      end
      CALC: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          w_state_nxt = CALC;
          w_latch     = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Control and result registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      p       <= '0;
      ovf     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      done    <= 1'b0;
      if (w_latch) begin
        r_cnt <= '0;
        busy  <= 1'b1;
      end else if (r_state == CALC) begin
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          busy <= 1'b0;
          done <= 1'b1;
          p    <= w_acc_nxt;
          ovf  <= |w_acc_nxt[PW-1:QW];
        end
      end
    end
  end

  // Operand and accumulator registers carry no reset; the FSM qualifies them.
  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_q   <= q;
      r_b   <= b;
      r_acc <= {{QW{1'b0}}, r};
    end else if (r_state == CALC) begin
      r_acc <= w_acc_nxt;
    end
  end

`ifdef DIV_INV_CHECK_EN
  logic [BW-1:0] r_r;

  always_ff @(posedge clk) begin
    if (w_latch) r_r <= r;
  end

  // A legal divider output has a nonzero divisor and a remainder below it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (w_last) begin
      err <= (r_b == '0) || (r_r >= r_b);
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_div_inverse_mul.sv
// Self-checking bench for div_inverse_mul: directed table, handshake corner
// sequences and randomized operands against an arithmetic reference.
module tb_div_inverse_mul;

  localparam int QW = 8;
  localparam int BW = 4;
  localparam int PW = QW + BW;

  logic          clk;
  logic          reset;
  logic [QW-1:0] q;
  logic [BW-1:0] b;
  logic [BW-1:0] r;
  logic          start;
  logic [PW-1:0] p;
  logic          ovf;
  logic          err;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_errors = 0;

  div_inverse_mul #(.QW(QW), .BW(BW)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (q),
    .b     (b),
    .r     (r),
    .start (start),
    .p     (p),
    .ovf   (ovf),
    .err   (err),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [QW-1:0] q;
    logic [BW-1:0] b;
    logic [BW-1:0] r;
    logic [PW-1:0] p;
    logic          ovf;
    logic          bad;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic exp_err(input logic bad);
`ifdef DIV_INV_CHECK_EN
    return bad;
`else
    return 1'b0 & bad;
`endif
  endfunction

  // Counts rising edges until done is seen; 0 means it never came.
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        n = i + 1;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [QW-1:0] iq, input logic [BW-1:0] ib,
                        input logic [BW-1:0] ir, input logic [PW-1:0] ep,
                        input logic eovf, input logic eerr, input string tag);
    int n;
    @(negedge clk);
    q = iq; b = ib; r = ir; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    q = QW'($urandom); b = BW'($urandom); r = BW'($urandom);
    chk({tag, ".busy_on"}, busy, 1);
    wait_done(n);
    chk({tag, ".latency"}, n, BW);
    chk({tag, ".p"}, p, ep);
    chk({tag, ".ovf"}, ovf, eovf);
    chk({tag, ".err"}, err, eerr);
    chk({tag, ".busy_off"}, busy, 0);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, done, 0);
    chk({tag, ".p_hold"}, p, ep);
  endtask

  vec_t vecs[7];

  initial begin
    int n;
    logic [QW-1:0] rq;
    logic [BW-1:0] rb, rr;
    int unsigned mp;
    logic seen;

    vecs[0] = '{8'd4,   4'd4,  4'd0,  12'd16,   1'b0, 1'b0};
    vecs[1] = '{8'd2,   4'd11, 4'd2,  12'd24,   1'b0, 1'b0};
    vecs[2] = '{8'd255, 4'd15, 4'd14, 12'd3839, 1'b1, 1'b0};
    vecs[3] = '{8'd26,  4'd5,  4'd4,  12'd134,  1'b0, 1'b0};
    vecs[4] = '{8'd0,   4'd11, 4'd6,  12'd6,    1'b0, 1'b0};
    vecs[5] = '{8'd6,   4'd0,  4'd0,  12'd0,    1'b0, 1'b1};
    vecs[6] = '{8'd1,   4'd5,  4'd6,  12'd11,   1'b0, 1'b1};

    reset = 1'b1; start = 1'b0; q = '0; b = '0; r = '0;
    #12;
    chk("reset.p", p, 0);
    chk("reset.ovf", ovf, 0);
    chk("reset.err", err, 0);
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].q, vecs[i].b, vecs[i].r, vecs[i].p, vecs[i].ovf,
             exp_err(vecs[i].bad), $sformatf("vec%0d", i));

    // Back-to-back: start held during DONE launches the next operation.
    @(negedge clk);
    q = 8'd2; b = 4'd11; r = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    chk("b2b.first_latency", n, BW);
    chk("b2b.first_p", p, 24);
    q = 8'd1; b = 4'd5; r = 4'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b.busy_again", busy, 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        n = i + 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("b2b.second_latency", n, BW + 1);
    chk("b2b.second_p", p, 6);
    chk("b2b.second_ovf", ovf, 0);

    // Busy protection: a new start during CALC must not disturb the operands.
    @(posedge clk); #1;
    @(negedge clk);
    q = 8'd3; b = 4'd7; r = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    q = 8'd200; b = 4'd15; r = 4'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        n = i + 3;
        break;
      end
      @(posedge clk); #1;
    end
    chk("busyprot.latency", n, BW);
    chk("busyprot.p", p, 23);
    chk("busyprot.ovf", ovf, 0);
    @(posedge clk); #1;
    chk("busyprot.no_restart", busy, 0);

    // Reset during the third CALC cycle aborts with no done pulse.
    @(negedge clk);
    q = 8'd9; b = 4'd9; r = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rstmid.busy", busy, 0);
    chk("rstmid.done", done, 0);
    chk("rstmid.p", p, 0);
    chk("rstmid.ovf", ovf, 0);
    @(negedge clk); reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    chk("rstmid.no_done", seen, 0);
    run_op(8'd9, 4'd9, 4'd3, 12'd84, 1'b0, 1'b0, "rstmid.after");

    // Randomized operands against plain arithmetic.
    for (int i = 0; i < 40; i++) begin
      rq = QW'($urandom);
      rb = BW'($urandom);
      rr = BW'($urandom);
      if (i % 5 == 0) rq = '1;
      if (i % 7 == 0) rb = '0;
      mp = int'(rq) * int'(rb) + int'(rr);
      run_op(rq, rb, rr, PW'(mp), (mp >= (1 << QW)),
             exp_err((rb == 0) || (rr >= rb)), $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
